// File: rtl/axi_arb_pkg.sv
// Shared constants and types for the AXI read arbiter: FSM encoding, requester IDs and fixed AR attributes.
package axi_arb_pkg;

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_AR   = 4'b0010;
  localparam logic [3:0] S_R    = 4'b0100;
  localparam logic [3:0] S_DONE = 4'b1000;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  localparam logic [2:0] ARSIZE_WORD  = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_req_t;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker; grant[0]=inst, grant[1]=data, zero latency.
// ARB_RR_EN: round-robin on the last-grant pointer; otherwise data has fixed priority.
module arb_pick2 (
  input  logic       req_inst,
  input  logic       req_data,
`ifdef ARB_RR_EN
  input  logic       last_inst,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
`ifdef ARB_RR_EN
    if (req_inst && req_data) begin
      grant = last_inst ? 2'b10 : 2'b01;
    end else begin
      grant = {req_data, req_inst};
    end
`else
    if (req_data) begin
      grant = 2'b10;
    end else if (req_inst) begin
      grant = 2'b01;
    end
`endif
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel between icache and dcache: arvalid 1 cycle after req, R beats forwarded combinationally by ID.
// Channel held until the granted burst's rlast plus one DONE cycle; ARB_RR_EN selects round-robin, else data-first priority.
module axi_rd_arbiter
  import axi_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_i,
  input  logic [31:0] inst_araddr_i,
  input  logic [3:0]  inst_arlen_i,
  input  logic        data_req_i,
  input  logic [31:0] data_araddr_i,
  input  logic [3:0]  data_arlen_i,
  output logic        inst_rvalid_o,
  output logic        data_rvalid_o,
  output logic [31:0] rdata_o,
  output logic [3:0]  rid_o,
  output logic        rlast_o,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  ar_req_t    lat;
  logic [1:0] grant;
  logic       owner_req;
  logic       abandon;
  logic       id_match;
  logic       fwd;
  logic       unused_rresp;

  assign unused_rresp = ^rresp;

`ifdef ARB_RR_EN
  logic last_inst;

  arb_pick2 u_pick (
    .req_inst  (inst_req_i),
    .req_data  (data_req_i),
    .last_inst (last_inst),
    .grant     (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_inst <= 1'b1;
    end else if (state == S_IDLE && grant != 2'b00) begin
      last_inst <= grant[0];
    end
  end
`else
  arb_pick2 u_pick (
    .req_inst (inst_req_i),
    .req_data (data_req_i),
    .grant    (grant)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign id_match = (rid == lat.id);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (grant != 2'b00) state_nxt = S_AR;
      S_AR:   if (arready) state_nxt = S_R;
      S_R:    if (rvalid && id_match && rlast) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Abandon is sticky so a requester that clears mid-burst never sees the tail of its old burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat     <= '{id: ID_INST, addr: '0, len: '0};
      abandon <= 1'b0;
    end else if (state == S_IDLE && grant != 2'b00) begin
      abandon <= 1'b0;
      if (grant[1]) begin
        lat <= '{id: ID_DATA, addr: data_araddr_i, len: data_arlen_i};
      end else begin
        lat <= '{id: ID_INST, addr: inst_araddr_i, len: inst_arlen_i};
      end
    end else if ((state == S_AR || state == S_R) && !owner_req) begin
      abandon <= 1'b1;
    end
  end

  assign owner_req = (lat.id == ID_DATA) ? data_req_i : inst_req_i;

  always_comb begin
    arvalid       = (state == S_AR);
    rready        = (state == S_R);
    fwd           = (state == S_R) && rvalid && id_match && owner_req && !abandon;
    inst_rvalid_o = fwd && (lat.id == ID_INST);
    data_rvalid_o = fwd && (lat.id == ID_DATA);
  end

  assign arid    = lat.id;
  assign araddr  = lat.addr;
  assign arlen   = lat.len;
  assign arsize  = ARSIZE_WORD;
  assign arburst = ARBURST_INCR;

  assign rdata_o = rdata;
  assign rid_o   = rid;
  assign rlast_o = rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboarded bench for axi_rd_arbiter: a transaction-level model predicts AR order and forwarded beats; a monitor checks them.
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } exp_ar_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req_i = 1'b0;
  logic [31:0] inst_araddr_i = '0;
  logic [3:0]  inst_arlen_i = '0;
  logic        data_req_i = 1'b0;
  logic [31:0] data_araddr_i = '0;
  logic [3:0]  data_arlen_i = '0;
  logic        inst_rvalid_o, data_rvalid_o, rlast_o, arvalid, rready;
  logic [31:0] rdata_o, araddr;
  logic [3:0]  rid_o, arid, arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  exp_ar_t ar_q[$];
  beat_t   inst_q[$];
  beat_t   data_q[$];
  exp_ar_t inst_b[$];
  exp_ar_t data_b[$];
  int  ar_delay_cfg = -1;
  int  stray_at = -1;
  bit  noise_en = 1'b0;
  bit  slave_busy = 1'b0;
  int  inst_fwd = 0;
  bit  model_last_inst = 1'b1;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_araddr_i(inst_araddr_i), .inst_arlen_i(inst_arlen_i),
    .data_req_i(data_req_i), .data_araddr_i(data_araddr_i), .data_arlen_i(data_arlen_i),
    .inst_rvalid_o(inst_rvalid_o), .data_rvalid_o(data_rvalid_o),
    .rdata_o(rdata_o), .rid_o(rid_o), .rlast_o(rlast_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return (a + 32'(b * 4)) ^ 32'hA5A5_0000;
  endfunction

  // Slave side of the AXI bridge: accepts AR after a delay and returns len+1 beats, optionally with stray rid=2 beats.
  task automatic drive_beat(input logic [3:0] id, input logic [31:0] d, input logic l, output bit ok);
    int t;
    t = 0;
    ok = 1'b0;
    rvalid = 1'b1; rid = id; rdata = d; rlast = l;
    while (t < 50) begin
      @(negedge clk);
      if (rst) return;
      if (rready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
      t++;
    end
    fail_now("rready_timeout");
  endtask

  task automatic run_slave_burst();
    logic [3:0]  sid;
    logic [31:0] sa;
    logic [3:0]  sl;
    int d;
    bit ok;
    d = (ar_delay_cfg >= 0) ? ar_delay_cfg : int'($urandom_range(0, 2));
    repeat (d) begin
      @(posedge clk); #1;
      if (rst) return;
    end
    arready = 1'b1;
    sid = arid; sa = araddr; sl = arlen;
    @(posedge clk); #1;
    arready = 1'b0;
    if (rst) return;
    for (int b = 0; b <= int'(sl); b++) begin
      if (b == stray_at || (noise_en && $urandom_range(0, 3) == 0)) begin
        drive_beat(4'd2, $urandom, 1'b1, ok);
        if (!ok) return;
      end
      drive_beat(sid, beat_data(sa, b), (b == int'(sl)), ok);
      if (!ok) return;
      if (noise_en && $urandom_range(0, 2) == 0) begin
        rvalid = 1'b0;
        @(posedge clk); #1;
        if (rst) return;
      end
    end
  endtask

  initial begin : slave
    forever begin
      @(posedge clk); #1;
      if (rst || !arvalid) continue;
      slave_busy = 1'b1;
      run_slave_burst();
      arready = 1'b0;
      rvalid = 1'b0;
      rlast = 1'b0;
      slave_busy = 1'b0;
    end
  end

  initial begin : monitor
    bit prev_pend;
    bit prev_arv;
    int cyc;
    int last_end;
    exp_ar_t e;
    beat_t bt;
    prev_pend = 1'b0; prev_arv = 1'b0; cyc = 0; last_end = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_pend = 1'b0; prev_arv = 1'b0; last_end = -1;
        continue;
      end
      if (prev_pend) chk("arvalid_hold", arvalid, 1);
      if (arvalid && !prev_arv && last_end >= 0) chk("last_to_ar_gap_ge2", 32'((cyc - last_end) >= 2), 1);
      if (arvalid && arready) begin
        if (ar_q.size() == 0) begin
          fail_now("ar_unexpected");
        end else begin
          e = ar_q.pop_front();
          chk("arid", arid, e.id);
          chk("araddr", araddr, e.addr);
          chk("arlen", arlen, e.len);
          chk("arsize", arsize, 3'b010);
          chk("arburst", arburst, 2'b01);
        end
      end
      if (inst_rvalid_o && data_rvalid_o) fail_now("both_rvalid_o");
      if (inst_rvalid_o) begin
        inst_fwd++;
        if (inst_q.size() == 0) begin
          fail_now("inst_beat_unexpected");
        end else begin
          bt = inst_q.pop_front();
          chk("inst_rdata", rdata_o, bt.data);
          chk("inst_rlast", rlast_o, bt.last);
          chk("inst_rid", rid_o, 4'd0);
        end
      end
      if (data_rvalid_o) begin
        if (data_q.size() == 0) begin
          fail_now("data_beat_unexpected");
        end else begin
          bt = data_q.pop_front();
          chk("data_rdata", rdata_o, bt.data);
          chk("data_rlast", rlast_o, bt.last);
          chk("data_rid", rid_o, 4'd1);
        end
      end
      if (rvalid && rid == 4'd2) chk("stray_passthru", rdata_o, rdata);
      if (rvalid && rready && rlast && rid != 4'd2) last_end = cyc;
      prev_pend = arvalid && !arready;
      prev_arv = arvalid;
    end
  end

  // Requester: holds req across its bursts, swaps fields right after each last beat, or clears early when abandoning.
  task automatic drv(input bit is_data, input bit abandon);
    exp_ar_t bl[$];
    int t;
    if (is_data) bl = data_b; else bl = inst_b;
    if (bl.size() == 0) return;
    foreach (bl[i]) begin
      if (is_data) begin
        data_req_i = 1'b1; data_araddr_i = bl[i].addr; data_arlen_i = bl[i].len;
      end else begin
        inst_req_i = 1'b1; inst_araddr_i = bl[i].addr; inst_arlen_i = bl[i].len;
      end
      if (abandon) begin
        repeat (2) begin @(posedge clk); #1; end
        break;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!((is_data ? data_rvalid_o : inst_rvalid_o) && rlast_o) && t < 2000);
      if (t >= 2000) fail_now(is_data ? "data_last_timeout" : "inst_last_timeout");
      @(posedge clk); #1;
    end
    if (is_data) data_req_i = 1'b0; else inst_req_i = 1'b0;
  endtask

  task automatic run_round(input bit abandon);
    int pi, pd, ii, di, t;
    bit pick_d;
    exp_ar_t e;
    pi = inst_b.size(); pd = data_b.size(); ii = 0; di = 0;
    while (pi > 0 || pd > 0) begin
      if (pi > 0 && pd > 0) pick_d = RR ? model_last_inst : 1'b1;
      else pick_d = (pd > 0);
      if (pick_d) begin e = data_b[di]; di++; pd--; end
      else begin e = inst_b[ii]; ii++; pi--; end
      model_last_inst = !pick_d;
      ar_q.push_back(e);
      if (!abandon) begin
        for (int b = 0; b <= int'(e.len); b++) begin
          if (pick_d) data_q.push_back('{beat_data(e.addr, b), b == int'(e.len)});
          else inst_q.push_back('{beat_data(e.addr, b), b == int'(e.len)});
        end
      end
    end
    fork
      drv(1'b0, abandon);
      drv(1'b1, abandon);
    join
    t = 0;
    while ((ar_q.size() != 0 || inst_q.size() != 0 || data_q.size() != 0 || slave_busy) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) begin
      fail_now("round_drain_timeout");
      ar_q.delete(); inst_q.delete(); data_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int ni, input int nd);
    logic [31:0] a;
    inst_b.delete();
    data_b.delete();
    for (int i = 0; i < ni; i++) begin
      a = $urandom; a[1:0] = 2'b00;
      inst_b.push_back('{4'd0, a, 4'($urandom_range(0, 7))});
    end
    for (int i = 0; i < nd; i++) begin
      a = $urandom; a[1:0] = 2'b00;
      data_b.push_back('{4'd1, a, 4'($urandom_range(0, 7))});
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t;
    int ni, nd;
    bit ab;
    int base;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_inst_rvalid_o", inst_rvalid_o, 0);
    chk("rst_data_rvalid_o", data_rvalid_o, 0);
    chk("rst_arid", arid, 4'd0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Inst refill only, arready the same cycle.
    ar_delay_cfg = 0;
    inst_b.delete(); data_b.delete();
    inst_b.push_back('{4'd0, 32'h1FC0_0010, 4'd3});
    run_round(1'b0);

    // Simultaneous requests: data first after reset (pointer inst-last or fixed priority).
    ar_delay_cfg = -1;
    fill(1, 1);
    run_round(1'b0);

    // Data keeps requesting back to back while inst waits.
    fill(1, 2);
    run_round(1'b0);

    // Inst clears during a 5-cycle AR stall: AR held, burst drained, nothing forwarded.
    ar_delay_cfg = 5;
    inst_b.delete(); data_b.delete();
    inst_b.push_back('{4'd0, 32'h0000_1000, 4'd3});
    run_round(1'b1);
    ar_delay_cfg = -1;

    // Stray rid=2 beat (with rlast) inside an inst burst.
    stray_at = 1;
    inst_b.delete(); data_b.delete();
    inst_b.push_back('{4'd0, 32'h0000_2040, 4'd3});
    run_round(1'b0);
    stray_at = -1;

    // Reset during the third beat of an inst refill.
    ar_delay_cfg = 0;
    base = inst_fwd;
    ar_q.push_back('{4'd0, 32'h0000_3000, 4'd3});
    inst_q.push_back('{beat_data(32'h0000_3000, 0), 1'b0});
    inst_q.push_back('{beat_data(32'h0000_3000, 1), 1'b0});
    inst_req_i = 1'b1; inst_araddr_i = 32'h0000_3000; inst_arlen_i = 4'd3;
    t = 0;
    while (inst_fwd < base + 2 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (t >= 200) fail_now("rst_test_beat_timeout");
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_arvalid", arvalid, 0);
    chk("midrst_rready", rready, 0);
    chk("midrst_state_idle", dut.state, S_IDLE);
    chk("midrst_inst_rvalid_o", inst_rvalid_o, 0);
    inst_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_beats_left", 32'(inst_q.size() + ar_q.size()), 0);
    ar_q.delete(); inst_q.delete(); data_q.delete();
    model_last_inst = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ar_delay_cfg = -1;
    inst_b.delete(); data_b.delete();
    inst_b.push_back('{4'd0, 32'h0000_4000, 4'd1});
    run_round(1'b0);

    // Randomized rounds with noise on the R channel.
    noise_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      ni = $urandom_range(0, 2);
      nd = $urandom_range(0, 2);
      if (ni == 0 && nd == 0) ni = 1;
      ab = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        ab = 1'b1;
        if ($urandom_range(0, 1) == 0) begin ni = 1; nd = 0; end
        else begin ni = 0; nd = 1; end
        ar_delay_cfg = 5;
      end
      fill(ni, nd);
      run_round(ab);
      ar_delay_cfg = -1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares the single AXI read-address/read-data channel between the instruction cache (refill or uncached fetch) and the data cache (refill or uncached load). It grants one requester at a time, drives one AR transaction, and routes R beats back by ID. It holds the channel until the granted burst's last beat, then returns to idle. It sits between the two caches and the top-level AXI bridge.

## Interface
- ID_INST, 4'd0, arid/rid value for instruction requests (icache filters on rid==0)
- ID_DATA, 4'd1, arid/rid value for data requests
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high (polarity and synchronicity fixed for this block)
- inst_req_i  in  1  icache read request, level, held until its last beat
- inst_araddr_i  in  32  icache burst address
- inst_arlen_i  in  4  icache burst length-1 (0 uncached, 3 refill)
- data_req_i / data_araddr_i / data_arlen_i  in  1/32/4  same for dcache
- inst_rvalid_o, data_rvalid_o  out  1  per-requester beat valid
- rdata_o  out  32  beat data, shared by both requesters
- rid_o  out  4  beat ID, shared
- rlast_o  out  1  last beat, shared
- arid, araddr, arlen  out  4/32/4  AXI AR fields
- arsize, arburst  out  3/2  constant 3'b010, 2'b01 (INCR)
- arvalid  out  1 ; arready  in  1
- rid, rdata, rresp, rlast, rvalid  in  4/32/2/1/1 ; rready  out  1

## Operation
- FSM states: IDLE, AR, R, DONE.
- IDLE: if any req_i is high, pick a winner (see Configuration). Latch its ID, araddr and arlen into registers. Go to AR.
- AR: arvalid=1 with latched fields. On arvalid&arready, go to R. arvalid is never withdrawn before the handshake, even if the requester drops req.
- R: rready=1. A beat is accepted when rvalid&rready.
  - rid==latched ID: forward as <owner>_rvalid_o=rvalid, but only while the owner's req_i is still high.
  - rid≠latched ID: consume and drop. No rvalid_o.
  - Accepted beat with rlast and matching ID: go to DONE.
- DONE: one idle cycle so requesters can lower req after their last beat. Then go to IDLE.
- Abandon: if the owner drops req in AR or R (cache clear), the burst is still fully drained. Forwarding is suppressed from the drop cycle onward.
- rdata_o/rid_o/rlast_o pass rdata/rid/rlast through combinationally in every state.
- rresp is ignored; errors are not reported.
- Reset values: state=IDLE, arvalid=0, rready=0, all rvalid_o=0, latched ID=ID_INST, latched araddr/arlen=0, rr pointer=inst-last.

## Timing
- Request to arvalid: 1 cycle (req high in IDLE at edge N, arvalid high after edge N).
- AR handshake to first forwarded beat: set by the slave. Forwarding is combinational, with zero added latency.
- Last beat to next arvalid: at least 2 cycles (DONE, then IDLE arbitration).
- Both requests high in IDLE in the same cycle: exactly one grant. The loser keeps its req and is granted after DONE.
- Async rst mid-burst: FSM returns to IDLE immediately. Outstanding AXI beats after reset are the bridge's responsibility.

## Configuration
- ARB_RR_EN defined: two-way round-robin. The winner is the requester not granted last; the pointer updates on each grant.
- ARB_RR_EN undefined: fixed priority, data over instruction. The pointer logic is removed.

## Structure
- Package axi_arb_pkg holds:
  - state encoding localparams (one-hot 4'b0001..4'b1000)
  - ID_INST/ID_DATA defaults
  - AXI constants ARSIZE_WORD and ARBURST_INCR
- Sub-module arb_pick2: combinational two-way picker. Inputs: two reqs and the last-grant pointer. Outputs: one-hot grant. It contains the ARB_RR_EN choice.

## Test plan
- Inst refill only: inst_req, addr 0x1FC0_0010, len 3, arready same cycle. Required: arid=0, araddr=0x1FC0_0010, four inst_rvalid_o pulses, data_rvalid_o never high, DONE then IDLE.
- Simultaneous inst and data requests with ARB_RR_EN, last grant=inst. Required: data granted first (arid=1), then inst after DONE.
- Same simultaneous requests without ARB_RR_EN, repeated twice. Required: data granted both times while data_req_i stays high.
- arready delayed 5 cycles, inst_req dropped at cycle 2. Required: arvalid stays high until the handshake, four beats are drained with rready=1, and inst_rvalid_o stays 0.
- Stray beat with rid=2 during an inst burst. Required: beat consumed, no rvalid_o, burst completes normally on rid=0 rlast.
- rst asserted during the third beat. Required: arvalid=0, rready=0, state=IDLE in the same cycle; a new request after release issues a fresh AR.
